mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM state encoding and
// requester identifiers.
package mem_arbiter_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_CPU = 2'd1;
  localparam logic [1:0] BUSY_EXT = 2'd2;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_EXT = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select between the CPU and EXT requesters.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise EXT wins a tie.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic cpu_elig,
  input  logic ext_elig,
  input  logic last,
  output logic valid,
  output logic id
);

  logic tie_id;

`ifdef MEM_ARB_RR_EN
  // On a tie, the requester that was not granted last time wins.
  assign tie_id = (last == REQ_EXT) ? REQ_CPU : REQ_EXT;
`else
  logic unused_last;
  assign unused_last = last;
  assign tie_id      = REQ_EXT;
`endif

  assign valid = cpu_elig | ext_elig;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    id = REQ_CPU;
    if (cpu_elig && ext_elig) id = tie_id;
    else if (ext_elig)        id = REQ_EXT;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / EXT) single-port memory arbiter with a 3-state FSM.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 cpu_req,
  input  logic                 cpu_write,
  input  logic [word_size-1:0] cpu_addr,
  input  logic [word_size-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [word_size-1:0] cpu_rdata,

  input  logic                 ext_req,
  input  logic                 ext_write,
  input  logic [word_size-1:0] ext_addr,
  input  logic [word_size-1:0] ext_wdata,
  output logic                 ext_ack,
  output logic [word_size-1:0] ext_rdata,

  output logic [word_size-1:0] mem_address,
  output logic [word_size-1:0] mem_data_in,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_data_out,

  output logic                 busy
);

  logic [1:0] state;
  logic       last;
  logic       cpu_elig;
  logic       ext_elig;
  logic       grant_valid;
  logic       grant_id;

  // A requester whose ack is high this cycle is still holding its old request.
  assign cpu_elig = cpu_req & ~cpu_ack;
  assign ext_elig = ext_req & ~ext_ack;

  arb_pick u_pick (
    .cpu_elig (cpu_elig),
    .ext_elig (ext_elig),
    .last     (last),
    .valid    (grant_valid),
    .id       (grant_id)
  );

  always_comb begin
    mem_address = '0;
    mem_data_in = '0;
    mem_write   = 1'b0;
    case (state)
      BUSY_CPU: begin
        mem_address = cpu_addr;
        mem_data_in = cpu_wdata;
        mem_write   = cpu_write;
      end
      BUSY_EXT: begin
        mem_address = ext_addr;
        mem_data_in = ext_wdata;
        mem_write   = ext_write;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: only the arbiter's own registers are reset; the memory is not, so a
  // write strobed during the reset cycle still lands while its ack is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state     <= IDLE;
      last      <= REQ_EXT;
      cpu_ack   <= 1'b0;
      ext_ack   <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ext_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state <= (grant_id == REQ_EXT) ? BUSY_EXT : BUSY_CPU;
            last  <= grant_id;
          end
        end
        BUSY_CPU: begin
          state   <= IDLE;
          cpu_ack <= 1'b1;
          if (!cpu_write) cpu_rdata <= mem_data_out;
        end
        BUSY_EXT: begin
          state   <= IDLE;
          ext_ack <= 1'b1;
          if (!ext_write) ext_rdata <= mem_data_out;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
